mux_arbiter_rr4: RTL
====================

# mux_arbiter_rr4

Four-requester round-robin arbiter that shares one resource (memory port, write-back bus) among four pipeline clients. It drives the 2-bit `select_i` of the existing 4-to-1 data multiplexer, so the mux is steered by registered, fair grants. A grant is held until the resource signals completion, with an optional watchdog release.

## Interface

Parameters:
- `TIMEOUT`, 16: maximum granted cycles before forced release. Used only with the timeout feature; must be ≥2.

Ports:
- `clk_i`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_i`  in  4  request per client; bit k = client k.
- `done_i`  in  1  resource finished the current transfer; sampled only in BUSY.
- `grant_o`  out  4  one-hot grant, registered; all zero when idle.
- `select_o`  out  2  index of the granted client, wired to the mux `select_i`.
- `valid_o`  out  1  a grant is active (state BUSY).
- `timeout_o`  out  1  one-cycle pulse on a watchdog release; constant 0 without the macro.

## Operation

- States are IDLE and BUSY. A 2-bit priority pointer `ptr` names the highest-priority client.
- Pick rule: search `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first set `req_i` bit wins.
- IDLE:
  - If any `req_i` bit is set, register the winner into `grant_o` and `select_o`, set `valid_o`=1, and go to BUSY.
  - Otherwise stay in IDLE.
  - `done_i` is ignored.
- BUSY:
  - Hold `grant_o` and `select_o` constant until release, even if the client drops its request.
  - A release occurs on `done_i`=1, or on a watchdog expiry (macro only).
- On release:
  - `ptr` becomes winner+1 (mod 4), and the pick rule runs on the current `req_i` using the new `ptr`.
  - If a request is found, the new grant appears the next cycle with no idle bubble, and the state stays BUSY.
  - If none is found, the next cycle has `grant_o`=0 and `valid_o`=0, and the state goes to IDLE.
- `select_o` keeps the last granted index while idle, so the mux output stays stable.
- `ptr` changes only on a release.

## Timing

- Reset values: state IDLE, `ptr`=0, `grant_o`=0000, `select_o`=00, `valid_o`=0, `timeout_o`=0. The watchdog counter is 0.
- Latency: a request sampled in IDLE at edge n gives a grant visible after edge n.
- Release at edge n puts the next grant (or idle) on the outputs after edge n.
- Each granted client holds the resource for at least 1 cycle.
- `rst_i`=1 in any state, including mid-transfer, forces the reset values at the next edge. Requests and `done_i` in that cycle are discarded.
- Simultaneous `done_i` and watchdog expiry in the same cycle: `done_i` wins and `timeout_o` stays 0.

## Configuration

- Macro: `MUX_ARB_TIMEOUT_EN`.
- Defined:
  - A watchdog counter of width $clog2(TIMEOUT+1) clears on every new grant and increments each BUSY cycle.
  - If the TIMEOUT-th granted cycle passes without `done_i`, a forced release occurs at that edge.
  - The release follows the normal rules, including `ptr` advance and back-to-back grant.
  - `timeout_o`=1 for exactly the cycle after that edge.
- Undefined:
  - No counter exists.
  - A grant is held indefinitely until `done_i`.
  - `timeout_o` is tied to 0.

## Structure

- Shared package `arb_pkg` holds:
  - the `NUM_REQ`=4 constant;
  - the state encoding (IDLE=0, BUSY=1);
  - the width of the select/pointer field (2).
- One combinational sub-module, `rr_pick4`:
  - inputs: `req`[3:0], `ptr`[1:0];
  - outputs: `idx`[1:0], `found`.
  - It is instantiated once and used for both the IDLE pick and the release re-pick.
- The top module holds the state register, the `ptr` register, the output registers and the optional watchdog.

## Test plan

- Reset: hold `rst_i`=1 for 2 cycles with `req_i`=1111 → `grant_o`=0000, `select_o`=00, `valid_o`=0. After release, the first grant goes to client 0.
- Single request: `req_i`=0100 in IDLE → next cycle `grant_o`=0100, `select_o`=10, `valid_o`=1. After a `done_i` pulse, next cycle `grant_o`=0000, `valid_o`=0, `select_o` still 10.
- Fairness: `req_i`=1111 held, `done_i` every 3rd granted cycle → grants go 0,1,2,3,0 back-to-back, with `valid_o` never dropping.
- Pointer wrap: client 2 releases, then `req_i`=0101 → grant to client 0 (search order 3,0,1,2), `select_o`=00.
- Watchdog, with macro and TIMEOUT=4: `req_i`=0001, `done_i`=0 → grant held exactly 4 cycles, then `timeout_o`=1 for one cycle and `grant_o`=0001 re-granted. Same stimulus with `done_i` in the 4th cycle → `timeout_o`=0. Macro off → grant held for 50+ cycles.
- Reset mid-BUSY: client 3 granted, `rst_i` pulsed for 1 cycle → next cycle all outputs take reset values and `ptr`=0.

Source files
------------

// File: rtl/mux_arbiter_rr4_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_t;

    function automatic req_t idx2onehot(input sel_t idx);
        req_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr4_if.sv
// Request/grant bundle between the four clients and the round-robin arbiter.
interface mux_arbiter_rr4_if;
    import arb_pkg::*;

    req_t req_i;
    logic done_i;
    req_t grant_o;
    sel_t select_o;
    logic valid_o;
    logic timeout_o;

    modport master (
        output req_i, done_i,
        input  grant_o, select_o, valid_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output grant_o, select_o, valid_o, timeout_o
    );

endinterface

// File: rtl/mux_arbiter_rr4_pick.sv
// Combinational round-robin pick: first set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  req_t req,
    input  sel_t ptr,
    output sel_t idx,
    output logic found
);

    sel_t cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr + sel_t'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_rr4.sv
// Four-requester round-robin arbiter with held grants; optional watchdog release
// enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter_rr4
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input logic             clk_i,
    input logic             rst_i,
    mux_arbiter_rr4_if.slave bus
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    arb_state_e state_q, state_d;
    sel_t       ptr_q, ptr_d;
    req_t       grant_q, grant_d;
    sel_t       select_q, select_d;

    sel_t pick_ptr;
    sel_t pick_idx;
    logic pick_found;
    logic load_grant;
    logic expire;
    logic rel;

    // While busy, the search starts just past the current winner so a release can re-grant immediately.
    assign pick_ptr = (state_q == ST_BUSY) ? sel_t'(select_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req   (bus.req_i),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    assign expire    = (wd_q == WD_W'(TIMEOUT - 1));
    assign timeout_d = (state_q == ST_BUSY) && expire && !bus.done_i;

    always_comb begin
        wd_d = wd_q;
        if (load_grant) begin
            wd_d = '0;
        end else if (state_q == ST_BUSY) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign expire        = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign rel = (state_q == ST_BUSY) && (bus.done_i || expire);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        select_d   = select_q;
        load_grant = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load_grant = pick_found;
            end
            ST_BUSY: begin
                if (rel) begin
                    ptr_d = pick_ptr;
                    if (pick_found) begin
                        load_grant = 1'b1;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_grant) begin
            grant_d  = idx2onehot(pick_idx);
            select_d = pick_idx;
            state_d  = ST_BUSY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            select_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            select_q <= select_d;
        end
    end

    assign bus.grant_o  = grant_q;
    assign bus.select_o = select_q;
    assign bus.valid_o  = (state_q == ST_BUSY);

endmodule
